// File: rtl/arbiter16_rr_pkg.sv
// Shared definitions for the 16-requester round-robin arbiter.
//   - FSM state encoding (idle / grant)
//   - requester count, pointer and hold-counter widths
//   - helpers: one-hot to index encoder, lowest-set-bit isolation
package arbiter16_rr_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned PTR_W = 4;
  localparam int unsigned CNT_W = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  // OR-reduction encoder: exact for one-hot input, returns 0 for all-zero.
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

  // Two's-complement trick keeps only the lowest set bit.
  function automatic logic [N_REQ-1:0] lowest_set(input logic [N_REQ-1:0] v);
    return v & (~v + N_REQ'(1));
  endfunction

endpackage

// File: rtl/arbiter16_rr_pick16.sv
// rr_pick16: combinational round-robin pick.
// Ports:
//   i_req  [15:0] request vector
//   i_ptr  [3:0]  index with highest priority this round
//   o_pick [15:0] one-hot selected requester (zero when i_req is zero)
//   o_any         at least one request present
module rr_pick16
  import arbiter16_rr_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic             o_any
);

  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_masked;

  // Requests at or above the pointer win first; if none, wrap to the lowest index overall.
  assign w_mask   = {N_REQ{1'b1}} << i_ptr;
  assign w_masked = i_req & w_mask;

  assign o_pick = (w_masked != '0) ? lowest_set(w_masked) : lowest_set(i_req);
  assign o_any  = |i_req;

endmodule

// File: rtl/arbiter16_rr.sv
// arbiter16_rr: registered 16-requester round-robin arbiter with one-hot grant.
// Ports:
//   I_CLK      rising-edge clock
//   I_RESET    asynchronous active-high reset
//   I_ENABLE   allow new grants (a held grant is never revoked by this)
//   I_REQ      [15:0] level-sensitive requests
//   I_DONE     current owner releases its grant
//   O_GRANT    [15:0] registered one-hot grant, zero when idle
//   O_VALID    high iff O_GRANT is non-zero
//   O_TIMEOUT  one-cycle pulse after a release caused only by the hold timeout
// Parameter TIMEOUT_CYCLES: max grant length in cycles, 0 disables (0..65535).
module arbiter16_rr
  import arbiter16_rr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic             I_CLK,
  input  logic             I_RESET,
  input  logic             I_ENABLE,
  input  logic [N_REQ-1:0] I_REQ,
  input  logic             I_DONE,
  output logic [N_REQ-1:0] O_GRANT,
  output logic             O_VALID,
  output logic             O_TIMEOUT
);

  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0
                                                               : CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_grant;
  logic             r_valid;
  logic             r_timeout;

  state_e           w_state_nxt;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [N_REQ-1:0] w_grant_nxt;
  logic             w_valid_nxt;
  logic             w_timeout_nxt;

  logic [N_REQ-1:0] w_pick;
  logic             w_any;
  logic [PTR_W-1:0] w_owner_idx;
  logic             w_rel_done;
  logic             w_rel_drop;
  logic             w_rel_to;
  logic             w_release;

  rr_pick16 u_pick (
    .i_req  (I_REQ),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  assign w_owner_idx = onehot_to_idx(r_grant);

  // Release causes, listed in priority order; only the timeout alone raises the pulse.
  assign w_rel_done = I_DONE;
  assign w_rel_drop = ((I_REQ & r_grant) == '0);
  assign w_rel_to   = TO_EN && (r_cnt == TO_LAST);
  assign w_release  = w_rel_done || w_rel_drop || w_rel_to;

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_grant_nxt   = r_grant;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;

    case (r_state)
      StIdle: begin
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
        if (I_ENABLE && w_any) begin
          w_grant_nxt = w_pick;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = StGrant;
        end
      end

      StGrant: begin
        if (w_release) begin
          // Going through idle guarantees the one-cycle bubble between owners.
          w_grant_nxt   = '0;
          w_valid_nxt   = 1'b0;
          w_cnt_nxt     = '0;
          w_ptr_nxt     = w_owner_idx + PTR_W'(1);
          w_timeout_nxt = w_rel_to && !w_rel_done && !w_rel_drop;
          w_state_nxt   = StIdle;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_state   <= StIdle;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_grant   <= w_grant_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign O_GRANT   = r_grant;
  assign O_VALID   = r_valid;
  assign O_TIMEOUT = r_timeout;

endmodule

// File: tb/tb_arbiter16_rr.sv
// Self-checking bench for arbiter16_rr. Three instances (timeout 0, 4 and 1) share
// the same stimulus; each scenario pushes per-cycle expectations and compares after the edge.
module tb_arbiter16_rr;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        en   = 1'b0;
  logic        done = 1'b0;
  logic [15:0] req  = '0;

  logic [15:0] g0, g4, g1;
  logic        v0, v4, v1;
  logic        t0, t4, t1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          inst;
    logic [15:0] g;
    logic        t;
    string       tag;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  arbiter16_rr #(.TIMEOUT_CYCLES(0)) u_dut0 (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_REQ(req), .I_DONE(done),
    .O_GRANT(g0), .O_VALID(v0), .O_TIMEOUT(t0)
  );

  arbiter16_rr #(.TIMEOUT_CYCLES(4)) u_dut4 (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_REQ(req), .I_DONE(done),
    .O_GRANT(g4), .O_VALID(v4), .O_TIMEOUT(t4)
  );

  arbiter16_rr #(.TIMEOUT_CYCLES(1)) u_dut1 (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_REQ(req), .I_DONE(done),
    .O_GRANT(g1), .O_VALID(v1), .O_TIMEOUT(t1)
  );

  function automatic logic [17:0] observe(input int inst);
    case (inst)
      0:       return {g0, v0, t0};
      4:       return {g4, v4, t4};
      default: return {g1, v1, t1};
    endcase
  endfunction

  function automatic exp_t mk(input int inst, input logic [15:0] g, input logic t,
                              input string tag);
    exp_t e;
    e.inst = inst;
    e.g    = g;
    e.t    = t;
    e.tag  = tag;
    return e;
  endfunction

  // Downstream encoder as seen by the shared-resource mux.
  function automatic int enc16(input logic [15:0] oh);
    int idx;
    idx = 0;
    for (int i = 15; i >= 0; i--) if (oh[i]) idx = i;
    return idx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = 1'b0;
    req  = '0;
    done = 1'b0;
    tick();
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    exp_t        e;
    logic [17:0] act;
    #2;
    rst = 1'b1;
    en  = 1'b1;
    req = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      #1;
      q.push_back(mk(0, 16'h0000, 1'b0, "reset"));
      q.push_back(mk(4, 16'h0000, 1'b0, "reset"));
      q.push_back(mk(1, 16'h0000, 1'b0, "reset"));
      if (i == 1) tick();
      while (q.size() != 0) begin
        e   = q.pop_front();
        act = observe(e.inst);
        checks++;
        if (act !== {e.g, |e.g, e.t}) begin
          failures++;
          $display("FAIL %s[%0d] dut%0d: got grant=%h valid=%b timeout=%b, want grant=%h valid=%b timeout=%b",
                   e.tag, i, e.inst, act[17:2], act[1], act[0], e.g, |e.g, e.t);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_basic();
    exp_t        e;
    logic [17:0] act;
    logic [15:0] req_tbl [3] = '{16'h0010, 16'h0000, 16'h0000};
    logic [15:0] exp_tbl [3] = '{16'h0010, 16'h0000, 16'h0000};
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req = req_tbl[i];
      q.push_back(mk(0, exp_tbl[i], 1'b0, "basic"));
      tick();
      while (q.size() != 0) begin
        e   = q.pop_front();
        act = observe(e.inst);
        checks++;
        if (act !== {e.g, |e.g, e.t}) begin
          failures++;
          $display("FAIL %s[%0d] dut%0d: got grant=%h valid=%b timeout=%b, want grant=%h valid=%b timeout=%b",
                   e.tag, i, e.inst, act[17:2], act[1], act[0], e.g, |e.g, e.t);
        end
      end
      if (i == 0) begin
        checks++;
        if (enc16(g0) != 4) begin
          failures++;
          $display("FAIL basic_encode: got index %0d, want 4", enc16(g0));
        end
      end
    end
  endtask

  task automatic test_alternate();
    exp_t        e;
    logic [17:0] act;
    logic [15:0] exp_tbl [6] = '{16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'h0001, 16'h0000};
    do_reset();
    en  = 1'b1;
    req = 16'h8001;
    for (int i = 0; i < 6; i++) begin
      done = (i % 2 == 1);
      q.push_back(mk(0, exp_tbl[i], 1'b0, "alternate"));
      tick();
      while (q.size() != 0) begin
        e   = q.pop_front();
        act = observe(e.inst);
        checks++;
        if (act !== {e.g, |e.g, e.t}) begin
          failures++;
          $display("FAIL %s[%0d] dut%0d: got grant=%h valid=%b timeout=%b, want grant=%h valid=%b timeout=%b",
                   e.tag, i, e.inst, act[17:2], act[1], act[0], e.g, |e.g, e.t);
        end
      end
    end
    done = 1'b0;
  endtask

  task automatic test_timeout();
    exp_t        e;
    logic [17:0] act;
    logic [15:0] g4_tbl [7] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0100};
    logic        t4_tbl [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    en  = 1'b1;
    req = 16'h0100;
    for (int i = 0; i < 7; i++) begin
      q.push_back(mk(0, 16'h0100, 1'b0, "timeout_off"));
      q.push_back(mk(4, g4_tbl[i], t4_tbl[i], "timeout4"));
      q.push_back(mk(1, (i % 2 == 0) ? 16'h0100 : 16'h0000, (i % 2 == 1), "timeout1"));
      tick();
      while (q.size() != 0) begin
        e   = q.pop_front();
        act = observe(e.inst);
        checks++;
        if (act !== {e.g, |e.g, e.t}) begin
          failures++;
          $display("FAIL %s[%0d] dut%0d: got grant=%h valid=%b timeout=%b, want grant=%h valid=%b timeout=%b",
                   e.tag, i, e.inst, act[17:2], act[1], act[0], e.g, |e.g, e.t);
        end
      end
    end
  endtask

  task automatic test_timeout_done();
    exp_t        e;
    logic [17:0] act;
    logic [15:0] g4_tbl [6] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0100};
    do_reset();
    en  = 1'b1;
    req = 16'h0100;
    for (int i = 0; i < 6; i++) begin
      done = (i == 4);
      q.push_back(mk(4, g4_tbl[i], 1'b0, "timeout_done"));
      tick();
      while (q.size() != 0) begin
        e   = q.pop_front();
        act = observe(e.inst);
        checks++;
        if (act !== {e.g, |e.g, e.t}) begin
          failures++;
          $display("FAIL %s[%0d] dut%0d: got grant=%h valid=%b timeout=%b, want grant=%h valid=%b timeout=%b",
                   e.tag, i, e.inst, act[17:2], act[1], act[0], e.g, |e.g, e.t);
        end
      end
    end
    done = 1'b0;
  endtask

  task automatic test_timeout1_done();
    exp_t        e;
    logic [17:0] act;
    do_reset();
    en   = 1'b1;
    req  = 16'h0001;
    done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q.push_back(mk(1, (i % 2 == 0) ? 16'h0001 : 16'h0000, 1'b0, "timeout1_done"));
      q.push_back(mk(0, (i % 2 == 0) ? 16'h0001 : 16'h0000, 1'b0, "done_plain"));
      tick();
      while (q.size() != 0) begin
        e   = q.pop_front();
        act = observe(e.inst);
        checks++;
        if (act !== {e.g, |e.g, e.t}) begin
          failures++;
          $display("FAIL %s[%0d] dut%0d: got grant=%h valid=%b timeout=%b, want grant=%h valid=%b timeout=%b",
                   e.tag, i, e.inst, act[17:2], act[1], act[0], e.g, |e.g, e.t);
        end
      end
    end
    done = 1'b0;
  endtask

  task automatic test_drop_enable();
    exp_t        e;
    logic [17:0] act;
    logic [15:0] req_tbl [8] = '{16'h0088, 16'h0080, 16'h0080, 16'h0081,
                                 16'h0081, 16'h0081, 16'h0081, 16'h0081};
    logic        en_tbl  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        dn_tbl  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] exp_tbl [8] = '{16'h0008, 16'h0000, 16'h0080, 16'h0080,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0001};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req  = req_tbl[i];
      en   = en_tbl[i];
      done = dn_tbl[i];
      q.push_back(mk(0, exp_tbl[i], 1'b0, "drop_enable"));
      tick();
      while (q.size() != 0) begin
        e   = q.pop_front();
        act = observe(e.inst);
        checks++;
        if (act !== {e.g, |e.g, e.t}) begin
          failures++;
          $display("FAIL %s[%0d] dut%0d: got grant=%h valid=%b timeout=%b, want grant=%h valid=%b timeout=%b",
                   e.tag, i, e.inst, act[17:2], act[1], act[0], e.g, |e.g, e.t);
        end
      end
    end
    done = 1'b0;
  endtask

  task automatic test_fairness();
    exp_t        e;
    logic [17:0] act;
    logic [15:0] one;
    do_reset();
    en  = 1'b1;
    req = 16'hFFFF;
    one = 16'h0001;
    for (int i = 0; i < 34; i++) begin
      done = (i % 2 == 1);
      q.push_back(mk(0, (i % 2 == 0) ? (one << ((i / 2) % 16)) : 16'h0000, 1'b0, "fairness"));
      tick();
      while (q.size() != 0) begin
        e   = q.pop_front();
        act = observe(e.inst);
        checks++;
        if (act !== {e.g, |e.g, e.t}) begin
          failures++;
          $display("FAIL %s[%0d] dut%0d: got grant=%h valid=%b timeout=%b, want grant=%h valid=%b timeout=%b",
                   e.tag, i, e.inst, act[17:2], act[1], act[0], e.g, |e.g, e.t);
        end
      end
    end
    done = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t        e;
    logic [17:0] act;
    do_reset();
    en  = 1'b1;
    req = 16'h0400;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin
          q.push_back(mk(0, 16'h0400, 1'b0, "async_pre"));
          tick();
        end
        1: begin
          // Assert reset between edges; outputs must clear with no clock.
          #3;
          rst = 1'b1;
          #1;
          q.push_back(mk(0, 16'h0000, 1'b0, "async_clear"));
          q.push_back(mk(4, 16'h0000, 1'b0, "async_clear"));
          q.push_back(mk(1, 16'h0000, 1'b0, "async_clear"));
        end
        2: begin
          req = 16'hFFFF;
          q.push_back(mk(0, 16'h0000, 1'b0, "async_held"));
          tick();
        end
        default: begin
          rst = 1'b0;
          q.push_back(mk(0, 16'h0001, 1'b0, "async_regrant"));
          tick();
        end
      endcase
      while (q.size() != 0) begin
        e   = q.pop_front();
        act = observe(e.inst);
        checks++;
        if (act !== {e.g, |e.g, e.t}) begin
          failures++;
          $display("FAIL %s[%0d] dut%0d: got grant=%h valid=%b timeout=%b, want grant=%h valid=%b timeout=%b",
                   e.tag, i, e.inst, act[17:2], act[1], act[0], e.g, |e.g, e.t);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_alternate();
    test_timeout();
    test_timeout_done();
    test_timeout1_done();
    test_drop_enable();
    test_fairness();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arbiter16_rr.md
Name: arbiter16_rr

Overview:
Registered 16-requester round-robin arbiter producing a one-hot grant vector.
- O_GRANT feeds the 16-to-4 one-hot encoder directly, which produces the 4-bit index of the granted requester for the shared-resource mux/control path.
- Guarantees O_GRANT is all-zero or exactly one-hot, so the encoder's default (index 0) is only reached when O_VALID is low.
- Grants are held until the owner finishes, drops its request, or times out.

Parameters:
- TIMEOUT_CYCLES, default 0: maximum cycles a grant is held. 0 disables the timeout. Legal range 0..65535.

Ports:
- I_CLK  input  1  rising-edge clock
- I_RESET  input  1  reset: one clock; asynchronous, active-high
- I_ENABLE  input  1  allow new grants; 0 freezes arbitration but does not revoke a held grant
- I_REQ  input  16  per-requester request, level-sensitive
- I_DONE  input  1  current owner releases grant this cycle
- O_GRANT  output  16  one-hot registered grant; all-zero when idle
- O_VALID  output  1  high iff O_GRANT is non-zero
- O_TIMEOUT  output  1  one-cycle pulse when a grant was force-released by timeout

Behaviour:
- Reset (async assert, sync to I_CLK on deassert):
  - O_GRANT=16'h0000, O_VALID=0, O_TIMEOUT=0.
  - State=IDLE, priority pointer PTR=0, hold counter CNT=0.
- State IDLE:
  - If I_ENABLE=1 and I_REQ!=0, pick the first set bit of I_REQ searching from index PTR upward, wrapping 15->0.
  - Next cycle: O_GRANT=one-hot(pick), O_VALID=1, CNT=0, state=GRANT.
  - Grant latency from request to grant is 1 cycle.
- State GRANT, owner g:
  - O_GRANT is held stable.
  - CNT increments each cycle and saturates at 16'hFFFF.
  - Release conditions, evaluated each cycle in priority order:
    (a) I_DONE=1;
    (b) I_REQ[g]=0;
    (c) TIMEOUT_CYCLES!=0 and CNT==TIMEOUT_CYCLES-1.
  - On release, the next cycle gives O_GRANT=0, O_VALID=0, PTR=(g+1) mod 16, state=IDLE.
  - O_TIMEOUT=1 in that next cycle only if (c) alone caused the release. Done or drop coincident with timeout means no pulse.
- Mandatory one-cycle bubble: after any release the block spends at least one cycle in IDLE with O_VALID=0 before the next grant. Back-to-back grants are therefore spaced by at least 1 idle cycle.
- I_ENABLE=0 during GRANT: the grant continues and release rules still apply. The block then stays IDLE until I_ENABLE=1.
- I_REQ changes on non-owner bits during GRANT: ignored. Only the next IDLE sample matters.
- Fairness: a continuously requesting input waits at most 15 grants.
- PTR updates only on release, never on grant.
- TIMEOUT_CYCLES=1: every grant lasts exactly 1 cycle unless done or dropped. The timeout pulse still fires when neither occurs.
- Reset asserted mid-grant: outputs clear immediately (asynchronously) and PTR returns to 0.
- O_TIMEOUT is registered and is 0 in every cycle not immediately following a timeout release.

Decomposition:
- Shared package/header:
  - state encoding (IDLE=1'b0, GRANT=1'b1);
  - N_REQ=16;
  - hold-counter width 16.
- One natural sub-module: rr_pick16. It is combinational, with inputs req[15:0] and ptr[3:0] and outputs one-hot pick[15:0] and any. It is built by masking I_REQ with bits >= PTR and falling back to unmasked lowest-set-bit.
- Top level holds the FSM, the PTR/CNT registers and the output registers.

Test Plan:
- Reset, then I_REQ=16'h0010 with I_ENABLE=1 -> one cycle later O_GRANT=16'h0010, O_VALID=1. Encoder downstream reads 4.
- I_REQ=16'h8001 held; pulse I_DONE each grant -> grants alternate 16'h0001, 16'h8000, 16'h0001, with one idle cycle between each (PTR wrap 15->0).
- TIMEOUT_CYCLES=4, I_REQ=16'h0100 held, I_DONE=0 -> O_VALID high for exactly 4 cycles, then O_VALID=0 and O_TIMEOUT=1 for 1 cycle, then re-grant of 16'h0100.
- TIMEOUT_CYCLES=4 with I_DONE=1 on the 4th grant cycle -> release with O_TIMEOUT=0.
- Owner drops I_REQ[3] mid-grant while I_REQ[7]=1 -> O_GRANT=0 next cycle, then 16'h0080 the cycle after.
- I_RESET asserted asynchronously mid-grant of 16'h0400 -> O_GRANT=0 and O_VALID=0 immediately. After release with I_REQ=16'hFFFF, the first grant is 16'h0001.
